// File: rtl/audio_adc_sampler_if.sv
// Bundles the SPI ADC pins and the stereo sample outputs of audio_adc_sampler.
// master = sampler side, slave = ADC / sample consumer side.
`default_nettype none

interface audio_adc_sampler_if;
  logic        adc_miso;
  logic        adc_clk;
  logic        adc_cs;
  logic        adc_mosi;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  modport master (
    input  adc_miso,
    output adc_clk, adc_cs, adc_mosi,
    output left_sample, right_sample, sample_valid, busy, overrun
  );

  modport slave (
    output adc_miso,
    input  adc_clk, adc_cs, adc_mosi,
    input  left_sample, right_sample, sample_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/audio_adc_sampler.sv
// Stereo capture front end: every SAMPLE_PERIOD clocks reads both channels of a
// 12-bit SPI ADC and presents them as a 16-bit two's-complement left/right pair.
`default_nettype none

module audio_adc_sampler #(
  parameter int SAMPLE_PERIOD = 562,
  parameter int SCLK_HALF     = 6,
  parameter int CS_GAP        = 16
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  audio_adc_sampler_if.master bus
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int PMAX = (SCLK_HALF > CS_GAP) ? SCLK_HALF : CS_GAP;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [4:0] LAST_SLOT = 5'd16;
  localparam logic [4:0] FIRST_DATA_SLOT = 5'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase_cnt;
  logic [4:0]    slot;
  logic          high_phase;
  logic          ch;
  logic [11:0]   shift_reg;
  logic [11:0]   hold_left;

  logic          adc_clk_r;
  logic          adc_cs_r;
  logic          adc_mosi_r;
  logic [15:0]   left_r;
  logic [15:0]   right_r;
  logic          valid_r;
  logic          busy_r;
  logic          overrun_r;

  logic          tick;
  logic          setup_end;
  logic          half_end;
  logic          gap_end;

  assign tick      = (tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign setup_end = (phase_cnt == PW'(SCLK_HALF - 1));
  assign half_end  = (phase_cnt == PW'(SCLK_HALF - 1));
  assign gap_end   = (phase_cnt == PW'(CS_GAP - 1));

  // Command word: start, single-ended, channel select, MSB-first, then zeros.
  function automatic logic cmd_bit(input logic [4:0] idx, input logic sel);
    logic b;
    case (idx)
      5'd0, 5'd1, 5'd3: b = 1'b1;
      5'd2:             b = sel;
      default:          b = 1'b0;
    endcase
    return b;
  endfunction

  // Offset binary to two's complement, left-justified in 16 bits.
  function automatic logic [15:0] conv(input logic [11:0] d);
    return {~d[11], d[10:0], 4'b0000};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      phase_cnt  <= '0;
      slot       <= '0;
      high_phase <= 1'b0;
      ch         <= 1'b0;
      shift_reg  <= '0;
      hold_left  <= '0;
      adc_clk_r  <= 1'b0;
      adc_cs_r   <= 1'b1;
      adc_mosi_r <= 1'b0;
      left_r     <= '0;
      right_r    <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      valid_r  <= 1'b0;

      // Ticks that arrive mid-conversion are dropped, not queued.
      if (tick && state != S_IDLE) begin
        overrun_r <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (tick) begin
            ch        <= 1'b0;
            adc_cs_r  <= 1'b0;
            busy_r    <= 1'b1;
            phase_cnt <= '0;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (setup_end) begin
            phase_cnt  <= '0;
            slot       <= '0;
            high_phase <= 1'b0;
            adc_mosi_r <= cmd_bit(5'd0, ch);
            state      <= S_SHIFT;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end

        S_SHIFT: begin
          if (half_end) begin
            phase_cnt <= '0;
            if (!high_phase) begin
              adc_clk_r  <= 1'b1;
              high_phase <= 1'b1;
              if (slot >= FIRST_DATA_SLOT) begin
                shift_reg <= {shift_reg[10:0], bus.adc_miso};
              end
            end else begin
              adc_clk_r  <= 1'b0;
              high_phase <= 1'b0;
              if (slot == LAST_SLOT) begin
                adc_cs_r   <= 1'b1;
                adc_mosi_r <= 1'b0;
                if (!ch) begin
                  hold_left <= shift_reg;
                  state     <= S_GAP;
                end else begin
                  state <= S_DONE;
                end
              end else begin
                slot       <= slot + 5'd1;
                adc_mosi_r <= cmd_bit(slot + 5'd1, ch);
              end
            end
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end

        S_GAP: begin
          if (gap_end) begin
            phase_cnt <= '0;
            ch        <= 1'b1;
            adc_cs_r  <= 1'b0;
            state     <= S_SETUP;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end

        S_DONE: begin
          left_r  <= conv(hold_left);
          right_r <= conv(shift_reg);
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.adc_clk      = adc_clk_r;
  assign bus.adc_cs       = adc_cs_r;
  assign bus.adc_mosi     = adc_mosi_r;
  assign bus.left_sample  = left_r;
  assign bus.right_sample = right_r;
  assign bus.sample_valid = valid_r;
  assign bus.busy         = busy_r;
  assign bus.overrun      = overrun_r;

endmodule

`default_nettype wire
